// File: rtl/tempo_sequencer.sv
// rtl/tempo_sequencer.sv - round-timing controller: programs divider period, counts ticks per response window
// Optional pause support is compiled in with `define TEMPO_PAUSE_EN.
module tempo_sequencer #(
  parameter int W            = 27,
  parameter int INIT_PERIOD  = 100_000_000,
  parameter int MIN_PERIOD   = 25_000_000,
  parameter int STEP         = 5_000_000,
  parameter int WINDOW_TICKS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         hit,
  input  logic         miss,
`ifdef TEMPO_PAUSE_EN
  input  logic         pause,
`endif
  input  logic         tick,
  output logic [W-1:0] period,
  output logic         div_reset,
  output logic         round_active,
  output logic         round_pass,
  output logic         game_over,
  output logic [7:0]   level,
  output logic [3:0]   ticks_left
);

`ifdef TEMPO_PAUSE_EN
  typedef enum logic [2:0] {IDLE, ARM, RUN, SCORE, OVER, PAUSE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ARM, RUN, SCORE, OVER} state_t;
`endif

  localparam logic [W-1:0] INIT_P    = W'(INIT_PERIOD);
  localparam logic [W-1:0] MIN_P     = W'(MIN_PERIOD);
  localparam logic [W:0]   STEP_X    = (W+1)'(STEP);
  localparam logic [W:0]   FLOOR_SUM = (W+1)'(STEP) + (W+1)'(MIN_PERIOD);
  localparam logic [3:0]   WIN_T     = 4'(WINDOW_TICKS);

  state_t       state, state_next;
  logic         first_run;
  logic         count_tick;
  logic [W:0]   period_x;
  logic [W:0]   period_dec;
  logic [W-1:0] period_next;

  // Widened subtraction so a small period never wraps below the floor.
  always_comb begin
    period_x    = {1'b0, period};
    period_dec  = period_x - STEP_X;
    period_next = (period_x < FLOOR_SUM) ? MIN_P : period_dec[W-1:0];
  end

  always_comb begin
    state_next = state;
    count_tick = 1'b0;
    case (state)
      IDLE:  if (start) state_next = ARM;
      ARM:   state_next = RUN;
      RUN: begin
        if (miss) begin
          state_next = OVER;
        end else if (hit) begin
          state_next = SCORE;
`ifdef TEMPO_PAUSE_EN
        end else if (pause) begin
          state_next = PAUSE;
`endif
        end else if (tick && !first_run) begin
          count_tick = 1'b1;
          if (ticks_left == 4'd1) state_next = OVER;
        end
      end
      SCORE: state_next = ARM;
      OVER:  if (start) state_next = ARM;
`ifdef TEMPO_PAUSE_EN
      PAUSE: if (!pause) state_next = RUN;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      period     <= INIT_P;
      level      <= 8'd0;
      ticks_left <= 4'd0;
      first_run  <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == IDLE || state == OVER) && start) begin
        period <= INIT_P;
        level  <= 8'd0;
      end
      if (state == ARM) begin
        ticks_left <= WIN_T;
        first_run  <= 1'b1;
      end
`ifdef TEMPO_PAUSE_EN
      // The divider restarts from 0 on resume, so its first tick is masked again.
      if (state == PAUSE) first_run <= 1'b1;
`endif
      if (state == RUN) begin
        first_run <= 1'b0;
        if (count_tick) ticks_left <= ticks_left - 4'd1;
      end
      if (state == SCORE) begin
        level  <= (level == 8'd255) ? 8'd255 : level + 8'd1;
        period <= period_next;
      end
    end
  end

  always_comb begin
    round_active = (state == RUN);
    round_pass   = (state == SCORE);
    game_over    = (state == OVER);
    div_reset    = (state != RUN) && (state != SCORE);
  end

endmodule

// File: tb/tb_tempo_sequencer.sv
// tb/tb_tempo_sequencer.sv - directed self-checking bench for tempo_sequencer with a behavioural divider
module tb_tempo_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, hit, miss, tick;
`ifdef TEMPO_PAUSE_EN
  logic         pause;
`endif
  logic [W-1:0] period;
  logic         div_reset, round_active, round_pass, game_over;
  logic [7:0]   level;
  logic [3:0]   ticks_left;
  logic [W-1:0] div_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tempo_sequencer #(
    .W(W), .INIT_PERIOD(10), .MIN_PERIOD(4), .STEP(3), .WINDOW_TICKS(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hit(hit), .miss(miss),
`ifdef TEMPO_PAUSE_EN
    .pause(pause),
`endif
    .tick(tick), .period(period), .div_reset(div_reset),
    .round_active(round_active), .round_pass(round_pass), .game_over(game_over),
    .level(level), .ticks_left(ticks_left)
  );

  // Shared clock divider: tick is high while its count is 0.
  always_ff @(posedge clk) begin
    if (reset || div_reset) div_cnt <= '0;
    else if (div_cnt >= period - 8'd1) div_cnt <= '0;
    else div_cnt <= div_cnt + 8'd1;
  end
  assign tick = (div_cnt == '0);

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; hit = 1'b0; miss = 1'b0;
`ifdef TEMPO_PAUSE_EN
    pause = 1'b0;
`endif
    steps(2);
    chk("rst_div_reset", div_reset, 1);
    chk("rst_period", period, 10);
    chk("rst_level", level, 0);
    chk("rst_ticks_left", ticks_left, 0);
    chk("rst_round_active", round_active, 0);
    chk("rst_round_pass", round_pass, 0);
    chk("rst_game_over", game_over, 0);
    reset = 1'b0;
    steps(1);

    // 1: start -> ARM for one cycle -> RUN
    start = 1'b1; steps(1); start = 1'b0;
    chk("arm_div_reset", div_reset, 1);
    chk("arm_round_active", round_active, 0);
    steps(1);
    chk("run_round_active", round_active, 1);
    chk("run_div_reset", div_reset, 0);
    chk("run_period", period, 10);
    chk("run_ticks_left", ticks_left, 2);

    // 2: three passed rounds, period 10 -> 7 -> 4 -> 4
    steps(4);
    hit = 1'b1; steps(1); hit = 1'b0;
    chk("p1_round_pass", round_pass, 1);
    steps(1);
    chk("p1_level", level, 1);
    chk("p1_period", period, 7);
    chk("p1_round_pass_low", round_pass, 0);
    chk("p1_arm_div_reset", div_reset, 1);
    steps(3);
    hit = 1'b1; steps(1); hit = 1'b0;
    chk("p2_round_pass", round_pass, 1);
    steps(1);
    chk("p2_level", level, 2);
    chk("p2_period", period, 4);
    steps(2);
    hit = 1'b1; steps(1); hit = 1'b0;
    steps(1);
    chk("p3_level", level, 3);
    chk("p3_period_floor", period, 4);
    steps(1);

    // 4: hit and miss together -> OVER without a pass
    steps(1);
    hit = 1'b1; miss = 1'b1; steps(1); hit = 1'b0; miss = 1'b0;
    chk("hm_game_over", game_over, 1);
    chk("hm_round_pass", round_pass, 0);
    chk("hm_level_hold", level, 3);
    chk("hm_period_hold", period, 4);
    hit = 1'b1; steps(1); hit = 1'b0;
    chk("over_hit_ignored", level, 3);
    chk("over_stays", game_over, 1);
    start = 1'b1; steps(1); start = 1'b0;
    chk("restart_period", period, 10);
    chk("restart_level", level, 0);
    chk("restart_game_over", game_over, 0);
    steps(1);

    // 3: window timeout, counted ticks at RUN cycles 10 and 20
    steps(3);
    start = 1'b1; steps(1); start = 1'b0;
    steps(5);
    chk("to_c9_ticks", ticks_left, 2);
    steps(1);
    chk("to_c10_tick", tick, 1);
    chk("to_c10_ticks", ticks_left, 2);
    steps(1);
    chk("to_c11_ticks", ticks_left, 1);
    steps(9);
    chk("to_c20_tick", tick, 1);
    chk("to_c20_game_over", game_over, 0);
    chk("to_c20_ticks", ticks_left, 1);
    steps(1);
    chk("to_c21_game_over", game_over, 1);
    chk("to_c21_ticks", ticks_left, 0);
    chk("to_c21_round_active", round_active, 0);

    // 5: reset mid-RUN after one passed round
    start = 1'b1; steps(1); start = 1'b0;
    steps(3);
    hit = 1'b1; steps(1); hit = 1'b0;
    steps(2);
    steps(3);
    chk("mr_period", period, 7);
    chk("mr_level", level, 1);
    chk("mr_active", round_active, 1);
    reset = 1'b1; steps(1); reset = 1'b0;
    chk("mr_div_reset", div_reset, 1);
    chk("mr_level_rst", level, 0);
    chk("mr_period_rst", period, 10);
    chk("mr_active_rst", round_active, 0);
    chk("mr_ticks_rst", ticks_left, 0);
    steps(1);
    miss = 1'b1; steps(1); miss = 1'b0;
    chk("idle_miss_ignored", game_over, 0);

`ifdef TEMPO_PAUSE_EN
    // 6: pause mid-round freezes the window
    start = 1'b1; steps(1); start = 1'b0;
    steps(1);
    steps(12);
    chk("pz_ticks_before", ticks_left, 1);
    pause = 1'b1; steps(1);
    chk("pz_round_active", round_active, 0);
    chk("pz_div_reset", div_reset, 1);
    steps(29);
    chk("pz_ticks_frozen", ticks_left, 1);
    chk("pz_no_game_over", game_over, 0);
    pause = 1'b0; steps(1);
    chk("pz_resumed", round_active, 1);
    steps(10);
    chk("pz_c10_game_over", game_over, 0);
    steps(1);
    chk("pz_window_end", game_over, 1);
    chk("pz_ticks_zero", ticks_left, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
